wb_stage: RTL and testbench



---
 rtl/wb_stage_if.sv | 41 ++++
 rtl/wb_stage.sv | 132 +++++++++++++
 tb/tb_wb_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Purpose : bus bundle between the MEM stage / hazard unit and the writeback stage.
// Signals : stall, flush          - pipeline control from the hazard unit
//           mem_*                 - MEM/WB payload of the instruction leaving MEM
//           wb_*, instret         - registered writeback results (register-file write port,
//                                   forwarding source, load exception, retire count)
// Modports: master drives control + MEM payload and observes WB results;
//           slave is the writeback stage itself.
interface wb_stage_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic              mem_reg_we;
  logic [ADDR_W-1:0] mem_rd;
  logic [1:0]        mem_wb_sel;
  logic [DATA_W-1:0] mem_alu_res;
  logic [DATA_W-1:0] mem_pc4;
  logic [DATA_W-1:0] mem_load_word;
  logic [2:0]        mem_funct3;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_valid;
  logic              wb_exc;
  logic [63:0]       instret;

  modport master (
    output stall, flush, mem_valid, mem_reg_we, mem_rd, mem_wb_sel,
           mem_alu_res, mem_pc4, mem_load_word, mem_funct3,
    input  wb_we, wb_waddr, wb_wdata, wb_valid, wb_exc, instret
  );

  modport slave (
    input  stall, flush, mem_valid, mem_reg_we, mem_rd, mem_wb_sel,
           mem_alu_res, mem_pc4, mem_load_word, mem_funct3,
    output wb_we, wb_waddr, wb_wdata, wb_valid, wb_exc, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Purpose : RV32 writeback stage - MEM/WB pipeline register, load alignment and
//           sign/zero extension, result selection, load exception detection and
//           retired-instruction counter.
// Ports   : clk    - clock, all state on rising edge
//           rst    - asynchronous active-high reset, clears every output
//           io_bus - wb_stage_if slave: stall/flush, MEM payload in, WB results out
module wb_stage #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  io_bus
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned CNT_W = 64;

  localparam logic [SEL_W-1:0] SEL_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_LOAD = 2'b01;
  localparam logic [SEL_W-1:0] SEL_PC4  = 2'b10;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Registered state
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_valid;
  logic              r_exc;
  logic [CNT_W-1:0]  r_instret;

  // Combinational capture path
  logic [1:0]        w_off;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_load;
  logic              w_load_bad;
  logic              w_exc;
  logic [DATA_W-1:0] w_result;
  logic              w_we;
  logic              w_retire;

  assign w_off     = io_bus.mem_alu_res[1:0];
  // Bring the addressed byte/half down to bit 0 before extension.
  assign w_shifted = DATA_W'(io_bus.mem_load_word >> {w_off, 3'b000});

  // Load extension and illegal/misaligned detection.
  always_comb begin
    w_load     = io_bus.mem_load_word;
    w_load_bad = 1'b0;
    case (io_bus.mem_funct3)
      F3_LB:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LBU: w_load = {24'd0, w_shifted[7:0]};
      F3_LH: begin
        w_load     = {{16{w_shifted[15]}}, w_shifted[15:0]};
        w_load_bad = w_off[0];
      end
      F3_LHU: begin
        w_load     = {16'd0, w_shifted[15:0]};
        w_load_bad = w_off[0];
      end
      F3_LW: begin
        w_load     = io_bus.mem_load_word;
        w_load_bad = (w_off != 2'd0);
      end
      default: begin
        // Illegal width code: raw word passes through, exception raised.
        w_load     = io_bus.mem_load_word;
        w_load_bad = 1'b1;
      end
    endcase
  end

  // Only an actual load can raise a load exception.
  assign w_exc = (io_bus.mem_wb_sel == SEL_LOAD) && w_load_bad;

  // Result mux; reserved select code behaves as ALU.
  always_comb begin
    w_result = io_bus.mem_alu_res;
    case (io_bus.mem_wb_sel)
      SEL_ALU:  w_result = io_bus.mem_alu_res;
      SEL_LOAD: w_result = w_load;
      SEL_PC4:  w_result = io_bus.mem_pc4;
      default:  w_result = io_bus.mem_alu_res;
    endcase
  end

  // x0 is never written; excepting loads never reach the register file.
  assign w_we     = io_bus.mem_valid && io_bus.mem_reg_we &&
                    (io_bus.mem_rd != ADDR_W'(0)) && !w_exc;
  assign w_retire = io_bus.mem_valid && !w_exc;

  // MEM/WB register: flush beats stall beats capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_valid   <= 1'b0;
      r_exc     <= 1'b0;
      r_instret <= '0;
    end else if (io_bus.flush) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_valid   <= 1'b0;
      r_exc     <= 1'b0;
    end else if (!io_bus.stall) begin
      r_we      <= w_we;
      r_waddr   <= io_bus.mem_rd;
      r_wdata   <= w_result;
      r_valid   <= io_bus.mem_valid;
      r_exc     <= io_bus.mem_valid && w_exc;
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign io_bus.wb_we    = r_we;
  assign io_bus.wb_waddr = r_waddr;
  assign io_bus.wb_wdata = r_wdata;
  assign io_bus.wb_valid = r_valid;
  assign io_bus.wb_exc   = r_exc;
  assign io_bus.instret  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Purpose : directed self-checking bench for wb_stage; expected WB state is queued
//           when each MEM entry is driven and compared after the capturing edge.
module tb_wb_stage;

  logic clk;
  logic rst;

  wb_stage_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  wb_stage #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        valid;
    logic        we;
    logic        exc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_data;
    logic [63:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic drive(input logic v, input logic rwe, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] word,
                       input logic [2:0] f3, input logic stl, input logic fl);
    bus.mem_valid     = v;
    bus.mem_reg_we    = rwe;
    bus.mem_rd        = rd;
    bus.mem_wb_sel    = sel;
    bus.mem_alu_res   = alu;
    bus.mem_pc4       = pc4;
    bus.mem_load_word = word;
    bus.mem_funct3    = f3;
    bus.stall         = stl;
    bus.flush         = fl;
  endtask

  task automatic expect_wb(input string tag, input logic v, input logic we,
                           input logic exc, input logic [4:0] addr,
                           input logic [31:0] data, input logic chk,
                           input logic [63:0] ir);
    exp_t e;
    e.tag = tag; e.valid = v; e.we = we; e.exc = exc; e.addr = addr;
    e.data = data; e.chk_data = chk; e.ir = ir;
    exp_q.push_back(e);
  endtask

  task automatic cmp1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare WB outputs against the oldest queued entry.
  task automatic edge_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      cmp1({e.tag, ".valid"},   64'(bus.wb_valid), 64'(e.valid));
      cmp1({e.tag, ".we"},      64'(bus.wb_we),    64'(e.we));
      cmp1({e.tag, ".exc"},     64'(bus.wb_exc),   64'(e.exc));
      cmp1({e.tag, ".waddr"},   64'(bus.wb_waddr), 64'(e.addr));
      if (e.chk_data) cmp1({e.tag, ".wdata"}, 64'(bus.wb_wdata), 64'(e.data));
      cmp1({e.tag, ".instret"}, bus.instret, e.ir);
    end
  endtask

  task automatic check_all_zero(input string tag);
    cmp1({tag, ".valid"},   64'(bus.wb_valid), 64'd0);
    cmp1({tag, ".we"},      64'(bus.wb_we),    64'd0);
    cmp1({tag, ".exc"},     64'(bus.wb_exc),   64'd0);
    cmp1({tag, ".waddr"},   64'(bus.wb_waddr), 64'd0);
    cmp1({tag, ".wdata"},   64'(bus.wb_wdata), 64'd0);
    cmp1({tag, ".instret"}, bus.instret,       64'd0);
  endtask

  localparam logic [31:0] LWORD = 32'h80FF7F01;

  initial begin
    rst = 1'b1;
    drive(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // ALU write
    drive(1, 1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("alu", 1, 1, 0, 5'd5, 32'h00001234, 1, 64'd1);
    edge_check();

    // Load extension
    drive(1, 1, 5'd6, 2'b01, 32'h2003, 32'h0, LWORD, 3'b000, 0, 0);
    expect_wb("lb_off3", 1, 1, 0, 5'd6, 32'hFFFFFF80, 1, 64'd2);
    edge_check();
    drive(1, 1, 5'd6, 2'b01, 32'h2003, 32'h0, LWORD, 3'b100, 0, 0);
    expect_wb("lbu_off3", 1, 1, 0, 5'd6, 32'h00000080, 1, 64'd3);
    edge_check();
    drive(1, 1, 5'd6, 2'b01, 32'h2002, 32'h0, LWORD, 3'b001, 0, 0);
    expect_wb("lh_off2", 1, 1, 0, 5'd6, 32'hFFFF80FF, 1, 64'd4);
    edge_check();
    drive(1, 1, 5'd6, 2'b01, 32'h2002, 32'h0, LWORD, 3'b101, 0, 0);
    expect_wb("lhu_off2", 1, 1, 0, 5'd6, 32'h000080FF, 1, 64'd5);
    edge_check();
    drive(1, 1, 5'd6, 2'b01, 32'h2001, 32'h0, LWORD, 3'b000, 0, 0);
    expect_wb("lb_off1", 1, 1, 0, 5'd6, 32'h0000007F, 1, 64'd6);
    edge_check();
    drive(1, 1, 5'd6, 2'b01, 32'h2000, 32'h0, LWORD, 3'b010, 0, 0);
    expect_wb("lw_aligned", 1, 1, 0, 5'd6, LWORD, 1, 64'd7);
    edge_check();

    // Misaligned and illegal loads
    drive(1, 1, 5'd7, 2'b01, 32'h1002, 32'h0, LWORD, 3'b010, 0, 0);
    expect_wb("lw_misal", 1, 0, 1, 5'd7, 32'h0, 0, 64'd7);
    edge_check();
    drive(1, 1, 5'd7, 2'b01, 32'h2001, 32'h0, LWORD, 3'b001, 0, 0);
    expect_wb("lh_misal", 1, 0, 1, 5'd7, 32'h0, 0, 64'd7);
    edge_check();
    // Exception level persists while stalled
    drive(1, 1, 5'd8, 2'b00, 32'h4444, 32'h0, 32'h0, 3'b000, 1, 0);
    expect_wb("exc_stall", 1, 0, 1, 5'd7, 32'h0, 0, 64'd7);
    edge_check();
    drive(1, 1, 5'd7, 2'b01, 32'h2000, 32'h0, 32'hDEADBEEF, 3'b011, 0, 0);
    expect_wb("illegal_f3", 1, 0, 1, 5'd7, 32'hDEADBEEF, 1, 64'd7);
    edge_check();
    // Illegal funct3 without a load select raises nothing
    drive(1, 1, 5'd8, 2'b00, 32'h55, 32'h0, 32'h0, 3'b011, 0, 0);
    expect_wb("f3_nonload", 1, 1, 0, 5'd8, 32'h55, 1, 64'd8);
    edge_check();

    // x0 and PC+4 / reserved select
    drive(1, 1, 5'd0, 2'b00, 32'h99, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("x0", 1, 0, 0, 5'd0, 32'h99, 1, 64'd9);
    edge_check();
    drive(1, 1, 5'd1, 2'b10, 32'h777, 32'h104, 32'h0, 3'b000, 0, 0);
    expect_wb("pc4", 1, 1, 0, 5'd1, 32'h104, 1, 64'd10);
    edge_check();
    drive(1, 1, 5'd2, 2'b11, 32'h321, 32'h104, 32'h0, 3'b000, 0, 0);
    expect_wb("sel_rsvd", 1, 1, 0, 5'd2, 32'h321, 1, 64'd11);
    edge_check();

    // Stall: three held edges, one retirement
    drive(1, 1, 5'd9, 2'b00, 32'hAAAA, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("pre_stall", 1, 1, 0, 5'd9, 32'hAAAA, 1, 64'd12);
    edge_check();
    drive(1, 1, 5'd10, 2'b00, 32'hBBBB, 32'h0, 32'h0, 3'b000, 1, 0);
    for (int i = 0; i < 3; i++) begin
      expect_wb("stall_hold", 1, 1, 0, 5'd9, 32'hAAAA, 1, 64'd12);
      edge_check();
    end
    drive(1, 1, 5'd10, 2'b00, 32'hBBBB, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("post_stall", 1, 1, 0, 5'd10, 32'hBBBB, 1, 64'd13);
    edge_check();

    // Bubble
    drive(0, 1, 5'd3, 2'b00, 32'hCC, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("bubble", 0, 0, 0, 5'd3, 32'hCC, 1, 64'd13);
    edge_check();

    // Flush, and flush together with stall
    drive(1, 1, 5'd11, 2'b00, 32'hDD, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("pre_flush", 1, 1, 0, 5'd11, 32'hDD, 1, 64'd14);
    edge_check();
    drive(1, 1, 5'd12, 2'b00, 32'hEE, 32'h0, 32'h0, 3'b000, 0, 1);
    expect_wb("flush", 0, 0, 0, 5'd0, 32'h0, 1, 64'd14);
    edge_check();
    drive(1, 1, 5'd12, 2'b00, 32'hEE, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("pre_sf", 1, 1, 0, 5'd12, 32'hEE, 1, 64'd15);
    edge_check();
    drive(1, 1, 5'd13, 2'b00, 32'hFF, 32'h0, 32'h0, 3'b000, 1, 1);
    expect_wb("stall_flush", 0, 0, 0, 5'd0, 32'h0, 1, 64'd15);
    edge_check();

    // Asynchronous reset mid-operation
    drive(1, 1, 5'd4, 2'b00, 32'h4321, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("pre_rst", 1, 1, 0, 5'd4, 32'h4321, 1, 64'd16);
    edge_check();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 5'd2, 2'b00, 32'h1, 32'h0, 32'h0, 3'b000, 0, 0);
    expect_wb("after_rst", 1, 1, 0, 5'd2, 32'h1, 1, 64'd1);
    edge_check();

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
